irig_frame_sync: RTL and testbench

//  Frame sequencer for the IRIG-B decode path. Consumes the per-symbol pulses (d0/d1/mark) from the width decoder.

---
 rtl/irig_pkg.sv | 38 +++
 rtl/irig_frame_sync_if.sv | 28 ++
 rtl/irig_symbol_watchdog.sv | 35 +++
 rtl/irig_frame_sync.sv | 166 ++++++++++++++++
 tb/tb_irig_frame_sync.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irig_pkg.sv
// irig_pkg: shared types and frame-position constants for the IRIG-B frame sequencer.
package irig_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ARMED,
    ST_FRAME,
    ST_ARMED_P0
  } sync_state_e;

  localparam logic [6:0] IDX_LAST = 7'd99;

  // LSB-first start positions of each captured field within the 100-symbol frame.
  localparam int IDX_SEC_UNITS  = 1;
  localparam int IDX_SEC_TENS   = 6;
  localparam int IDX_MIN_UNITS  = 10;
  localparam int IDX_MIN_TENS   = 15;
  localparam int IDX_HOUR_UNITS = 20;
  localparam int IDX_HOUR_TENS  = 25;
  localparam int IDX_DAY_UNITS  = 30;
  localparam int IDX_DAY_TENS   = 35;
  localparam int IDX_DAY_HUND   = 40;
  localparam int IDX_SBS_LO     = 80;
  localparam int IDX_SBS_HI     = 90;

  typedef struct packed {
    logic [9:0] day_bcd;
    logic [5:0] hour_bcd;
    logic [6:0] min_bcd;
    logic [6:0] sec_bcd;
  } time_fields_t;

  // Position markers sit at 9, 19, ..., 99; Pr (index 0) is handled by the FSM.
  function automatic logic is_marker_idx(input logic [6:0] idx);
    return (idx % 7'd10) == 7'd9;
  endfunction

endpackage

// File: rtl/irig_frame_sync_if.sv
// irig_frame_sync_if: symbol pulses from the width decoder in, frame status and latched time out.
interface irig_frame_sync_if;
  logic        irig_d0;
  logic        irig_d1;
  logic        irig_mark;
  logic [6:0]  bit_index;
  logic        frame_start;
  logic        ts_valid;
  logic        locked;
  logic        frame_err;
  logic [6:0]  sec_bcd;
  logic [6:0]  min_bcd;
  logic [5:0]  hour_bcd;
  logic [9:0]  day_bcd;
  logic [16:0] sbs_sec;

  modport master (
    output irig_d0, irig_d1, irig_mark,
    input  bit_index, frame_start, ts_valid, locked, frame_err,
           sec_bcd, min_bcd, hour_bcd, day_bcd, sbs_sec
  );

  modport slave (
    input  irig_d0, irig_d1, irig_mark,
    output bit_index, frame_start, ts_valid, locked, frame_err,
           sec_bcd, min_bcd, hour_bcd, day_bcd, sbs_sec
  );
endinterface

// File: rtl/irig_symbol_watchdog.sv
// irig_symbol_watchdog: counts idle cycles between symbols while active; pulses timeout_o
// on the cycle the count would reach SYM_TIMEOUT, then restarts.
module irig_symbol_watchdog #(
  parameter int SYM_TIMEOUT = 150000
) (
  input  logic clk,
  input  logic rst,
  input  logic sym_i,
  input  logic active_i,
  output logic timeout_o
);
  localparam int               CNT_W = (SYM_TIMEOUT > 1) ? $clog2(SYM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SYM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d     = cnt_q + 1'b1;
    timeout_o = 1'b0;
    if (!active_i || sym_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d     = '0;
      timeout_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irig_frame_sync.sv
// irig_frame_sync: IRIG-B frame sequencer -- finds Pr, tracks bit index, checks markers, declares
// lock and latches BCD time fields. Define IRIG_SBS_EN to also latch straight-binary seconds.
module irig_frame_sync
  import irig_pkg::*;
#(
  parameter int FRAMES_TO_LOCK = 2,
  parameter int SYM_TIMEOUT    = 150000
) (
  input  logic             clk,
  input  logic             rst,
  irig_frame_sync_if.slave bus
);
  localparam logic [3:0] LOCK_CNT = 4'(FRAMES_TO_LOCK);

  sync_state_e  state_q;
  logic [6:0]   bit_index_q;
  logic         frame_start_q, ts_valid_q, locked_q, frame_err_q;
  logic [3:0]   good_q, good_inc;
  time_fields_t fields_q, fields_d, out_q;

  logic       sym_any, sym_collide, sym_valid, timeout;
  logic [6:0] next_idx;
  logic       want_mark, capture_en, accept_last, seq_err;

  assign sym_any     = bus.irig_d0 | bus.irig_d1 | bus.irig_mark;
  assign sym_collide = (bus.irig_d0 & bus.irig_d1) | (bus.irig_d0 & bus.irig_mark) |
                       (bus.irig_d1 & bus.irig_mark);
  assign sym_valid   = sym_any & ~sym_collide;
  assign next_idx    = bit_index_q + 7'd1;
  assign want_mark   = is_marker_idx(next_idx);
  assign capture_en  = (state_q == ST_FRAME) && sym_valid && !bus.irig_mark;
  assign accept_last = (state_q == ST_FRAME) && sym_valid && bus.irig_mark && (next_idx == IDX_LAST);
  assign good_inc    = (good_q == LOCK_CNT) ? good_q : good_q + 4'd1;

  assign seq_err = sym_collide || timeout ||
                   ((state_q == ST_FRAME)    && sym_valid && (bus.irig_mark != want_mark)) ||
                   ((state_q == ST_ARMED_P0) && sym_valid && !bus.irig_mark);

  irig_symbol_watchdog #(.SYM_TIMEOUT(SYM_TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .sym_i     (sym_any),
    .active_i  (state_q != ST_SEARCH),
    .timeout_o (timeout)
  );

  // Data symbols are written straight into their BCD slot; a '1' symbol is a set bit.
  always_comb begin
    fields_d = fields_q;
    if (capture_en) begin
      for (int k = 0; k < 4; k++) begin
        if (next_idx == 7'(IDX_SEC_UNITS + k))  fields_d.sec_bcd[k]    = bus.irig_d1;
        if (next_idx == 7'(IDX_MIN_UNITS + k))  fields_d.min_bcd[k]    = bus.irig_d1;
        if (next_idx == 7'(IDX_HOUR_UNITS + k)) fields_d.hour_bcd[k]   = bus.irig_d1;
        if (next_idx == 7'(IDX_DAY_UNITS + k))  fields_d.day_bcd[k]    = bus.irig_d1;
        if (next_idx == 7'(IDX_DAY_TENS + k))   fields_d.day_bcd[4+k]  = bus.irig_d1;
      end
      for (int k = 0; k < 3; k++) begin
        if (next_idx == 7'(IDX_SEC_TENS + k))   fields_d.sec_bcd[4+k]  = bus.irig_d1;
        if (next_idx == 7'(IDX_MIN_TENS + k))   fields_d.min_bcd[4+k]  = bus.irig_d1;
      end
      for (int k = 0; k < 2; k++) begin
        if (next_idx == 7'(IDX_HOUR_TENS + k))  fields_d.hour_bcd[4+k] = bus.irig_d1;
        if (next_idx == 7'(IDX_DAY_HUND + k))   fields_d.day_bcd[8+k]  = bus.irig_d1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the capture shadow is reset along with the outputs so reset state is fully deterministic.
      state_q       <= ST_SEARCH;
      bit_index_q   <= '0;
      frame_start_q <= 1'b0;
      ts_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      good_q        <= '0;
      fields_q      <= '0;
      out_q         <= '0;
    end else begin
      frame_start_q <= 1'b0;
      ts_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      fields_q      <= fields_d;
      if (seq_err) begin
        // A misplaced mark may itself be the first half of a new reference pair.
        frame_err_q <= 1'b1;
        good_q      <= '0;
        locked_q    <= 1'b0;
        bit_index_q <= '0;
        state_q     <= (sym_valid && bus.irig_mark) ? ST_ARMED : ST_SEARCH;
      end else if (sym_valid) begin
        unique case (state_q)
          ST_SEARCH: begin
            if (bus.irig_mark) state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (bus.irig_mark) begin
              state_q       <= ST_FRAME;
              bit_index_q   <= '0;
              frame_start_q <= 1'b1;
            end else begin
              state_q <= ST_SEARCH;
            end
          end
          ST_FRAME: begin
            bit_index_q <= next_idx;
            if (accept_last) begin
              out_q      <= fields_q;
              ts_valid_q <= 1'b1;
              good_q     <= good_inc;
              locked_q   <= (good_inc == LOCK_CNT);
              state_q    <= ST_ARMED_P0;
            end
          end
          ST_ARMED_P0: begin
            state_q       <= ST_FRAME;
            bit_index_q   <= '0;
            frame_start_q <= 1'b1;
          end
          default: state_q <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.bit_index   = bit_index_q;
  assign bus.frame_start = frame_start_q;
  assign bus.ts_valid    = ts_valid_q;
  assign bus.locked      = locked_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.sec_bcd     = out_q.sec_bcd;
  assign bus.min_bcd     = out_q.min_bcd;
  assign bus.hour_bcd    = out_q.hour_bcd;
  assign bus.day_bcd     = out_q.day_bcd;

`ifdef IRIG_SBS_EN
  logic [16:0] sbs_shadow_q, sbs_shadow_d, sbs_q;

  always_comb begin
    sbs_shadow_d = sbs_shadow_q;
    if (capture_en) begin
      for (int k = 0; k < 9; k++)
        if (next_idx == 7'(IDX_SBS_LO + k)) sbs_shadow_d[k] = bus.irig_d1;
      for (int k = 0; k < 8; k++)
        if (next_idx == 7'(IDX_SBS_HI + k)) sbs_shadow_d[9+k] = bus.irig_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sbs_shadow_q <= '0;
      sbs_q        <= '0;
    end else begin
      sbs_shadow_q <= sbs_shadow_d;
      if (accept_last) sbs_q <= sbs_shadow_q;
    end
  end

  assign bus.sbs_sec = sbs_q;
`else
  assign bus.sbs_sec = '0;
`endif

endmodule

// File: tb/tb_irig_frame_sync.sv
// tb_irig_frame_sync: directed IRIG-B frames against a position-based reference model checked every cycle.
module tb_irig_frame_sync;
  localparam int LOCK_N     = 2;
  localparam int TB_TIMEOUT = 300;
  localparam int GAP        = 4;
  localparam int K_D0 = 0, K_D1 = 1, K_MARK = 2, K_COLL = 3, K_RST = 4;

  logic clk;
  logic rst;
  irig_frame_sync_if bus ();

  irig_frame_sync #(.FRAMES_TO_LOCK(LOCK_N), .SYM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0, n_total = 0;
  int cyc = 0, ts_cnt = 0, fs_cnt = 0, err_cnt = 0, last_sym_cyc = 0, err_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: m_pos is the frame position of the last accepted symbol,
  // -1 after a single unpaired mark, -2 with no reference at all.
  int m_pos = -2, m_idle = 0, m_good = 0;
  bit m_data [100];
  int e_idx = 0, e_lock = 0, e_sec = 0, e_min = 0, e_hour = 0, e_day = 0, e_sbs = 0;
  bit e_fs = 0, e_ts = 0, e_err = 0;

  function automatic int field(input int lo, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v += int'(m_data[lo+i]) << i;
    return v;
  endfunction

  task automatic lose(input bit rearm);
    e_err  = 1;
    m_good = 0;
    e_lock = 0;
    m_idle = 0;
    m_pos  = rearm ? -1 : -2;
  endtask

  task automatic model_step(input logic d0, input logic d1, input logic mk, input logic rs);
    int nsym, p;
    bit want;
    e_fs = 0; e_ts = 0; e_err = 0;
    if (!rs) begin
      m_pos = -2; m_idle = 0; m_good = 0;
      e_idx = 0; e_lock = 0; e_sec = 0; e_min = 0; e_hour = 0; e_day = 0; e_sbs = 0;
      return;
    end
    nsym = int'(d0) + int'(d1) + int'(mk);
    if (nsym > 1) begin
      lose(0);
    end else if (nsym == 1) begin
      m_idle = 0;
      if (m_pos == -2) begin
        if (mk) m_pos = -1;
      end else if (m_pos == -1) begin
        if (mk) begin m_pos = 0; e_fs = 1; end
        else m_pos = -2;
      end else begin
        p    = (m_pos + 1) % 100;
        want = (p % 10 == 9) || (p == 0);
        if (mk != want) lose(mk);
        else begin
          m_pos = p;
          if (p == 0) e_fs = 1;
          if (!mk) m_data[p] = d1;
          if (p == 99) begin
            e_ts   = 1;
            e_sec  = field(1, 4)  + 16 * field(6, 3);
            e_min  = field(10, 4) + 16 * field(15, 3);
            e_hour = field(20, 4) + 16 * field(25, 2);
            e_day  = field(30, 4) + 16 * field(35, 4) + 256 * field(40, 2);
`ifdef IRIG_SBS_EN
            e_sbs  = field(80, 9) + 512 * field(90, 8);
`endif
            m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
            e_lock = (m_good == LOCK_N) ? 1 : 0;
          end
        end
      end
    end else if (m_pos != -2) begin
      m_idle++;
      if (m_idle == TB_TIMEOUT) lose(0);
    end
    e_idx = (m_pos < 0) ? 0 : m_pos;
  endtask

  // Compare process: registered outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      model_step(bus.irig_d0, bus.irig_d1, bus.irig_mark, rst);
      if (bus.irig_d0 || bus.irig_d1 || bus.irig_mark) last_sym_cyc = cyc;
      if (bus.ts_valid === 1'b1)    ts_cnt++;
      if (bus.frame_start === 1'b1) fs_cnt++;
      if (bus.frame_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      check("bit_index",   32'(bus.bit_index),   32'(e_idx));
      check("frame_start", 32'(bus.frame_start), 32'(e_fs));
      check("ts_valid",    32'(bus.ts_valid),    32'(e_ts));
      check("frame_err",   32'(bus.frame_err),   32'(e_err));
      check("locked",      32'(bus.locked),      32'(e_lock));
      check("sec_bcd",     32'(bus.sec_bcd),     32'(e_sec));
      check("min_bcd",     32'(bus.min_bcd),     32'(e_min));
      check("hour_bcd",    32'(bus.hour_bcd),    32'(e_hour));
      check("day_bcd",     32'(bus.day_bcd),     32'(e_day));
      check("sbs_sec",     32'(bus.sbs_sec),     32'(e_sbs));
    end
  end

  int frame_sym [100];

  task automatic put(input int lo, input int val, input int n);
    for (int i = 0; i < n; i++) frame_sym[lo+i] = (val >> i) & 1;
  endtask

  task automatic build_frame(input int day, input int hour, input int mins, input int sec, input int sbs);
    for (int p = 0; p < 100; p++) frame_sym[p] = (p == 0 || p % 10 == 9) ? K_MARK : K_D0;
    put(1,  sec % 10, 4);   put(6,  sec / 10, 3);
    put(10, mins % 10, 4);  put(15, mins / 10, 3);
    put(20, hour % 10, 4);  put(25, hour / 10, 2);
    put(30, day % 10, 4);   put(35, (day / 10) % 10, 4);  put(40, day / 100, 2);
    put(80, sbs & 511, 9);  put(90, sbs >> 9, 8);
  endtask

  task automatic send_sym(input int kind);
    @(negedge clk);
    if (kind == K_RST) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst_bit_index", 32'(bus.bit_index), 32'd0);
      check("rst_locked",    32'(bus.locked),    32'd0);
      check("rst_sec",       32'(bus.sec_bcd),   32'd0);
      check("rst_day",       32'(bus.day_bcd),   32'd0);
      check("rst_ts_valid",  32'(bus.ts_valid),  32'd0);
    end else begin
      bus.irig_d0   = (kind == K_D0) || (kind == K_COLL);
      bus.irig_d1   = (kind == K_D1);
      bus.irig_mark = (kind == K_MARK) || (kind == K_COLL);
      @(negedge clk);
      bus.irig_d0 = 1'b0; bus.irig_d1 = 1'b0; bus.irig_mark = 1'b0;
    end
    repeat (GAP - 2) @(negedge clk);
  endtask

  task automatic send_frame(input int last);
    for (int p = 0; p <= last; p++) send_sym(frame_sym[p]);
  endtask

  int e0, t0;
  logic [16:0] sbs_a, sbs_b, sbs_d;

  initial begin
`ifdef IRIG_SBS_EN
    sbs_a = 17'd45296; sbs_b = 17'd86398; sbs_d = 17'd1;
`else
    sbs_a = 17'd0;     sbs_b = 17'd0;     sbs_d = 17'd0;
`endif
    rst = 1'b0;
    bus.irig_d0 = 1'b0; bus.irig_d1 = 1'b0; bus.irig_mark = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bit_index", 32'(bus.bit_index), 32'd0);
    check("reset_locked",    32'(bus.locked),    32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_hour",      32'(bus.hour_bcd),  32'd0);
    rst = 1'b1;

    // 1) two clean frames, day 123 12:34:56
    build_frame(123, 12, 34, 56, 45296);
    send_sym(K_MARK);
    send_frame(99);
    check("t1_ts_first",     32'(ts_cnt),      32'd1);
    check("t1_unlocked_1st", 32'(bus.locked),  32'd0);
    send_frame(99);
    check("t1_ts_count",  32'(ts_cnt),       32'd2);
    check("t1_fs_count",  32'(fs_cnt),       32'd2);
    check("t1_sec",       32'(bus.sec_bcd),  32'h56);
    check("t1_min",       32'(bus.min_bcd),  32'h34);
    check("t1_hour",      32'(bus.hour_bcd), 32'h12);
    check("t1_day",       32'(bus.day_bcd),  32'h123);
    check("t1_locked",    32'(bus.locked),   32'd1);
    check("t1_sbs",       32'(bus.sbs_sec),  32'(sbs_a));

    // 2) stray mark at idx 5, then relock on day 366 23:59:58
    e0 = err_cnt;
    frame_sym[5] = K_MARK;
    send_frame(99);
    check("t2_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t2_unlocked",   32'(bus.locked),   32'd0);
    build_frame(366, 23, 59, 58, 86398);
    send_frame(99);
    check("t2_relock_1st", 32'(bus.locked), 32'd0);
    send_frame(99);
    check("t2_relocked", 32'(bus.locked),   32'd1);
    check("t2_ts_count", 32'(ts_cnt),       32'd4);
    check("t2_sec",      32'(bus.sec_bcd),  32'h58);
    check("t2_hour",     32'(bus.hour_bcd), 32'h23);
    check("t2_day",      32'(bus.day_bcd),  32'h366);
    check("t2_sbs",      32'(bus.sbs_sec),  32'(sbs_b));

    // 3) symbols stop after idx 40
    e0 = err_cnt; t0 = ts_cnt;
    send_frame(40);
    repeat (TB_TIMEOUT + 20) @(negedge clk);
    check("t3_err_pulses",  32'(err_cnt - e0),          32'd1);
    check("t3_err_latency", 32'(err_cyc - last_sym_cyc), 32'd300);
    check("t3_bit_index",   32'(bus.bit_index),         32'd0);
    check("t3_no_ts",       32'(ts_cnt - t0),           32'd0);

    // 4) d0+mark collision at idx 12 of a frame carrying a different time
    e0 = err_cnt; t0 = ts_cnt;
    build_frame(45, 7, 8, 9, 1234);
    frame_sym[12] = K_COLL;
    send_sym(K_MARK);
    send_frame(99);
    check("t4_err_pulses", 32'(err_cnt - e0),  32'd1);
    check("t4_no_ts",      32'(ts_cnt - t0),   32'd0);
    check("t4_sec_kept",   32'(bus.sec_bcd),   32'h58);
    check("t4_min_kept",   32'(bus.min_bcd),   32'h59);
    check("t4_day_kept",   32'(bus.day_bcd),   32'h366);

    // 5) reset at idx 60, then a full frame day 200 00:00:01
    t0 = ts_cnt;
    build_frame(123, 12, 34, 56, 45296);
    frame_sym[60] = K_RST;
    send_frame(99);
    check("t5_no_ts_after_rst", 32'(ts_cnt - t0), 32'd0);
    build_frame(200, 0, 0, 1, 1);
    send_frame(99);
    check("t5_ts_count", 32'(ts_cnt - t0),   32'd1);
    check("t5_sec",      32'(bus.sec_bcd),   32'h01);
    check("t5_day",      32'(bus.day_bcd),   32'h200);
    check("t5_locked",   32'(bus.locked),    32'd0);
    check("t5_sbs",      32'(bus.sbs_sec),   32'(sbs_d));

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
